// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS pipeline.
// Build option IF_FLUSH_EN: no delay slot; the fetched word is squashed when a redirect lands.
//
//   state | meaning
//   RUN   | no redirect buffered; pc advances on each accepted fetch
//   PEND  | redirect target held in pend_pc_q until the outstanding fetch completes
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        nostall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid,
    output logic        redir_pend
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] dinst_q, dinst_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic        dvalid_q, dvalid_d;

    logic [31:0] pc4;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redir_req;

    assign pc4       = pc_q + 32'd4;
    assign redir_req = nostall && (pcsource != 2'b00);

    always_comb begin
        target_raw = jpc;
        case (pcsource)
            2'b01:   target_raw = bpc;
            2'b10:   target_raw = rpc;
            default: target_raw = jpc;
        endcase
    end

    assign target = {target_raw[31:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        dinst_d   = dinst_q;
        dpc4_d    = dpc4_q;
        dvalid_d  = dvalid_q;

        // A stall freezes everything; decode will re-present any redirect.
        if (nostall) begin
            if (!imem_ready) begin
                dinst_d  = NOP_INST;
                dvalid_d = 1'b0;
                if (redir_req) begin
                    state_d   = PEND;
                    pend_pc_d = target;
                end
            end else begin
                dinst_d  = imem_rdata;
                dpc4_d   = pc4;
                dvalid_d = 1'b1;
                if (redir_req) begin
                    pc_d = target;
                end else if (state_q == PEND) begin
                    pc_d = pend_pc_q;
                end else begin
                    pc_d = pc4;
                end
`ifdef IF_FLUSH_EN
                if (redir_req || (state_q == PEND)) begin
                    dinst_d  = NOP_INST;
                    dpc4_d   = dpc4_q;
                    dvalid_d = 1'b0;
                end
`endif
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= RUN;
            pc_q      <= {RESET_PC[31:2], 2'b00};
            pend_pc_q <= 32'h0000_0000;
            dinst_q   <= NOP_INST;
            dpc4_q    <= 32'h0000_0000;
            dvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            dinst_q   <= dinst_d;
            dpc4_q    <= dpc4_d;
            dvalid_q  <= dvalid_d;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign dpc4       = dpc4_q;
    assign dinst      = dinst_q;
    assign dvalid     = dvalid_q;
    assign redir_pend = (state_q == PEND);

endmodule

// File: tb/tb_pipe_if_stage.sv
// Scoreboard bench for pipe_if_stage; expectations adapt when built with IF_FLUSH_EN.
module tb_pipe_if_stage;

`ifdef IF_FLUSH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        nostall = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0, rpc = 32'h0, jpc = 32'h0;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ready = 1'b1;
    logic [31:0] pc, dpc4, dinst;
    logic        dvalid, redir_pend;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic        rstn;
        logic        ns;
        logic [1:0]  src;
        logic        rdy;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] j;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dpc4;
        logic [31:0] dinst;
        logic        dvalid;
        logic        pend;
    } exp_t;

    exp_t sb[$];

    pipe_if_stage dut (
        .clock      (clock),
        .resetn     (resetn),
        .nostall    (nostall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc         (pc),
        .dpc4       (dpc4),
        .dinst      (dinst),
        .dvalid     (dvalid),
        .redir_pend (redir_pend)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] W(input logic [31:0] a);
        return 32'h8C00_0000 ^ a;
    endfunction

    assign imem_rdata = W(imem_addr);

    function automatic stim_t S(input logic rstn, input logic ns, input logic [1:0] src,
                                input logic rdy, input logic [31:0] b, input logic [31:0] r,
                                input logic [31:0] j);
        S = '{rstn: rstn, ns: ns, src: src, rdy: rdy, b: b, r: r, j: j};
    endfunction

    function automatic exp_t X(input logic [31:0] p, input logic [31:0] d4, input logic [31:0] di,
                               input logic v, input logic pe);
        X = '{pc: p, dpc4: d4, dinst: di, dvalid: v, pend: pe};
    endfunction

    function automatic exp_t obs();
        obs = '{pc: pc, dpc4: dpc4, dinst: dinst, dvalid: dvalid, pend: redir_pend};
    endfunction

    task automatic drive(input stim_t s);
        resetn     = s.rstn;
        nostall    = s.ns;
        pcsource   = s.src;
        imem_ready = s.rdy;
        bpc        = s.b;
        rpc        = s.r;
        jpc        = s.j;
    endtask

    // Unchecked preamble: reset, then n plain sequential fetches.
    task automatic prime(input int n);
        drive(S(1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0));
        @(posedge clock); #1;
        for (int i = 0; i < n; i++) begin
            drive(S(1'b1, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0));
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, want;
        st.push_back(S(1'b0, 1'b1, 2'b11, 1'b1, 32'h40, 32'h80, 32'h100));
        ex.push_back(X(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(S(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0));
        ex.push_back(X(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clock); #1;
            got  = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL reset[%0d]: got pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b, want pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b",
                         i, got.pc, got.dpc4, got.dinst, got.dvalid, got.pend,
                         want.pc, want.dpc4, want.dinst, want.dvalid, want.pend);
            else passed++;
        end
    endtask

    task automatic test_free_run();
        exp_t got, want;
        for (int i = 0; i < 4; i++) begin
            drive(S(1'b1, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0));
            sb.push_back(X(32'(4 * (i + 1)), 32'(4 * (i + 1)), W(32'(4 * i)), 1'b1, 1'b0));
            @(posedge clock); #1;
            got  = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL free_run[%0d]: got pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b, want pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b",
                         i, got.pc, got.dpc4, got.dinst, got.dvalid, got.pend,
                         want.pc, want.dpc4, want.dinst, want.dvalid, want.pend);
            else passed++;
        end
    endtask

    task automatic test_wait();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, want;
        st.push_back(S(1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0));
        ex.push_back(X(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0));
        ex.push_back(X(32'h4, 32'h4, W(32'h0), 1'b1, 1'b0));
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0));
        ex.push_back(X(32'h8, 32'h8, W(32'h4), 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(S(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0));
            ex.push_back(X(32'h8, 32'h8, 32'h0, 1'b0, 1'b0));
        end
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0));
        ex.push_back(X(32'hC, 32'hC, W(32'h8), 1'b1, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clock); #1;
            got  = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL wait[%0d]: got pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b, want pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b",
                         i, got.pc, got.dpc4, got.dinst, got.dvalid, got.pend,
                         want.pc, want.dpc4, want.dinst, want.dvalid, want.pend);
            else passed++;
        end
    endtask

    task automatic test_branch();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, want;
        prime(4);
        // Low target bits are set deliberately; the stage must align them.
        st.push_back(S(1'b1, 1'b1, 2'b01, 1'b1, 32'h43, 32'hC00, 32'hD00));
        ex.push_back(FL ? X(32'h40, 32'h10, 32'h0, 1'b0, 1'b0)
                        : X(32'h40, 32'h14, W(32'h10), 1'b1, 1'b0));
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b1, 32'hB00, 32'hC00, 32'hD00));
        ex.push_back(X(32'h44, 32'h44, W(32'h40), 1'b1, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clock); #1;
            got  = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL branch[%0d]: got pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b, want pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b",
                         i, got.pc, got.dpc4, got.dinst, got.dvalid, got.pend,
                         want.pc, want.dpc4, want.dinst, want.dvalid, want.pend);
            else passed++;
        end
    endtask

    task automatic test_pending();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, want;
        prime(8);
        st.push_back(S(1'b1, 1'b1, 2'b10, 1'b0, 32'hB00, 32'h80, 32'hD00));
        ex.push_back(X(32'h20, 32'h20, 32'h0, 1'b0, 1'b1));
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b0, 32'hB00, 32'hC00, 32'hD00));
        ex.push_back(X(32'h20, 32'h20, 32'h0, 1'b0, 1'b1));
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b1, 32'hB00, 32'hC00, 32'hD00));
        ex.push_back(FL ? X(32'h80, 32'h20, 32'h0, 1'b0, 1'b0)
                        : X(32'h80, 32'h24, W(32'h20), 1'b1, 1'b0));
        // Newer redirect overwrites a buffered one.
        st.push_back(S(1'b1, 1'b1, 2'b01, 1'b0, 32'h300, 32'hC00, 32'hD00));
        ex.push_back(X(32'h80, FL ? 32'h20 : 32'h24, 32'h0, 1'b0, 1'b1));
        st.push_back(S(1'b1, 1'b1, 2'b11, 1'b0, 32'h300, 32'hC00, 32'h204));
        ex.push_back(X(32'h80, FL ? 32'h20 : 32'h24, 32'h0, 1'b0, 1'b1));
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b1, 32'hB00, 32'hC00, 32'hD00));
        ex.push_back(FL ? X(32'h204, 32'h20, 32'h0, 1'b0, 1'b0)
                        : X(32'h204, 32'h84, W(32'h80), 1'b1, 1'b0));
        // Same-cycle redirect beats the buffered target.
        st.push_back(S(1'b1, 1'b1, 2'b01, 1'b0, 32'h300, 32'hC00, 32'hD00));
        ex.push_back(X(32'h204, FL ? 32'h20 : 32'h84, 32'h0, 1'b0, 1'b1));
        st.push_back(S(1'b1, 1'b1, 2'b10, 1'b1, 32'h300, 32'h80, 32'hD00));
        ex.push_back(FL ? X(32'h80, 32'h20, 32'h0, 1'b0, 1'b0)
                        : X(32'h80, 32'h208, W(32'h204), 1'b1, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clock); #1;
            got  = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL pending[%0d]: got pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b, want pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b",
                         i, got.pc, got.dpc4, got.dinst, got.dvalid, got.pend,
                         want.pc, want.dpc4, want.dinst, want.dvalid, want.pend);
            else passed++;
        end
    endtask

    task automatic test_stall();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, want;
        logic [31:0] hd4;
        logic [31:0] hdi;
        logic        hv;
        prime(12);
        st.push_back(S(1'b0 ^ 1'b1, 1'b0, 2'b11, 1'b1, 32'hB00, 32'hC00, 32'h100));
        ex.push_back(X(32'h30, 32'h30, W(32'h2C), 1'b1, 1'b0));
        st.push_back(S(1'b1, 1'b1, 2'b11, 1'b1, 32'hB00, 32'hC00, 32'h100));
        ex.push_back(FL ? X(32'h100, 32'h30, 32'h0, 1'b0, 1'b0)
                        : X(32'h100, 32'h34, W(32'h30), 1'b1, 1'b0));
        hd4 = FL ? 32'h30 : 32'h34;
        hdi = FL ? 32'h0 : W(32'h30);
        hv  = !FL;
        // A stall must neither buffer a redirect nor insert a bubble.
        st.push_back(S(1'b1, 1'b0, 2'b01, 1'b0, 32'h200, 32'hC00, 32'hD00));
        ex.push_back(X(32'h100, hd4, hdi, hv, 1'b0));
        st.push_back(S(1'b1, 1'b0, 2'b00, 1'b1, 32'h200, 32'hC00, 32'hD00));
        ex.push_back(X(32'h100, hd4, hdi, hv, 1'b0));
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b1, 32'h200, 32'hC00, 32'hD00));
        ex.push_back(X(32'h104, 32'h104, W(32'h100), 1'b1, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clock); #1;
            got  = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL stall[%0d]: got pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b, want pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b",
                         i, got.pc, got.dpc4, got.dinst, got.dvalid, got.pend,
                         want.pc, want.dpc4, want.dinst, want.dvalid, want.pend);
            else passed++;
        end
    endtask

    task automatic test_reset_pend();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, want;
        prime(17);
        st.push_back(S(1'b1, 1'b1, 2'b01, 1'b0, 32'h200, 32'hC00, 32'hD00));
        ex.push_back(X(32'h44, 32'h44, 32'h0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b1, 2'b01, 1'b1, 32'h200, 32'hC00, 32'hD00));
        ex.push_back(X(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b1, 32'hB00, 32'hC00, 32'hD00));
        ex.push_back(X(32'h4, 32'h4, W(32'h0), 1'b1, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clock); #1;
            got  = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL reset_pend[%0d]: got pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b, want pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b",
                         i, got.pc, got.dpc4, got.dinst, got.dvalid, got.pend,
                         want.pc, want.dpc4, want.dinst, want.dvalid, want.pend);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, want;
        prime(1);
        st.push_back(S(1'b1, 1'b1, 2'b10, 1'b1, 32'hB00, 32'hFFFF_FFFF, 32'hD00));
        ex.push_back(FL ? X(32'hFFFF_FFFC, 32'h4, 32'h0, 1'b0, 1'b0)
                        : X(32'hFFFF_FFFC, 32'h8, W(32'h4), 1'b1, 1'b0));
        st.push_back(S(1'b1, 1'b1, 2'b00, 1'b1, 32'hB00, 32'hC00, 32'hD00));
        ex.push_back(X(32'h0, 32'h0, W(32'hFFFF_FFFC), 1'b1, 1'b0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(posedge clock); #1;
            got  = obs();
            want = sb.pop_front();
            checks++;
            if (got !== want)
                $display("FAIL wrap[%0d]: got pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b, want pc=%h dpc4=%h dinst=%h dvalid=%b pend=%b",
                         i, got.pc, got.dpc4, got.dinst, got.dvalid, got.pend,
                         want.pc, want.dpc4, want.dinst, want.dvalid, want.pend);
            else passed++;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_free_run();
        test_wait();
        test_branch();
        test_pending();
        test_stall();
        test_reset_pend();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
